// File: rtl/seq_chunk_adder.sv
// Multi-cycle wide adder: one CHUNK-bit slice per clock, carry registered between slices.
// Operands enter through a valid/ready handshake; result and flags are held until taken.
`timescale 1ns/1ps

module seq_chunk_slice_add #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);
  logic [CHUNK:0] total;

  assign total = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
  assign s     = total[CHUNK-1:0];
  assign co    = total[CHUNK];
endmodule

// state  | meaning
// S_IDLE | waiting for operands, in_ready high
// S_BUSY | adding slice cnt_q each cycle, carry held in carry_q
// S_DONE | result and flags valid, waiting for out_ready
module seq_chunk_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;

  logic [CHUNK-1:0] a_sl, b_sl, s_sl;
  logic             c_sl;
  logic [WIDTH-1:0] sum_d;
  logic             accept, last_slice;

  assign in_ready   = (state_q == S_IDLE) && !rst;
  assign accept     = in_valid && in_ready;
  assign last_slice = (cnt_q == LAST);
  assign out_valid  = (state_q == S_DONE);

  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (cnt_q == CW'(i)) begin
        a_sl = a_q[i*CHUNK +: CHUNK];
        b_sl = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  seq_chunk_slice_add #(.CHUNK(CHUNK)) u_slice (
    .x  (a_sl),
    .y  (b_sl),
    .ci (carry_q),
    .s  (s_sl),
    .co (c_sl)
  );

  // Sum register with the current slice merged in; on the last slice this is the final sum.
  always_comb begin
    sum_d = sum;
    for (int i = 0; i < NCHUNK; i++) begin
      if (cnt_q == CW'(i)) sum_d[i*CHUNK +: CHUNK] = s_sl;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_BUSY;
      S_BUSY:  if (last_slice) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            cnt_q   <= '0;
          end
        end
        S_BUSY: begin
          sum     <= sum_d;
          carry_q <= c_sl;
          // Counter parks on the last slice; only a new accept clears it.
          if (!last_slice) cnt_q <= cnt_q + CW'(1);
          if (last_slice) begin
            cout <= c_sl;
            ovf  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
            zero <= (sum_d == '0);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
